bus_arbiter: RTL and testbench

Round-robin arbiter that shares the single CPU data bus between up to 2^WIDTH requesters (CPU core, DMA, I/O ports). It keeps a registered winner index and expands it to a one-hot grant vector via the existing `decoder` block, with `gnt_valid` driving the decoder's `EN`. It enforces a bounded tenure per owner and inserts one dead cycle between owners for bus turnaround.

---
 rtl/bus_arbiter.sv | 143 ++++++++++++++
 tb/tb_bus_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with bounded tenure and a one-cycle turnaround gap between owners.
// Latency: grant one cycle after request from IDLE; next owner one cycle after release/preempt.
// Backpressure: none; requesters hold req until granted and for the whole transfer.
//
// Ports:
//   clk        - single clock, all state on rising edge
//   rst_n      - asynchronous active-low reset, clears all outputs immediately
//   req        - per-requester request vector (N = 2^WIDTH)
//   gnt        - one-hot grant, decoded from the registered owner index
//   gnt_idx    - registered owner index, holds last value while no grant is active
//   gnt_valid  - a grant is active (decoder enable)
//   busy       - arbiter is in GRANT or HANDOFF

// Index-to-one-hot decoder with enable; all outputs zero when disabled.
module decoder #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0]      a_i,
    input  logic                  en_i,
    output logic [(1<<WIDTH)-1:0] y_o
);
    always_comb begin
        y_o = '0;
        if (en_i) begin
            y_o[a_i] = 1'b1;
        end
    end
endmodule

module bus_arbiter #(
    parameter int WIDTH    = 3,
    parameter int MAX_HOLD = 16,
    parameter int CW       = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [(1<<WIDTH)-1:0] req,
    output logic [(1<<WIDTH)-1:0] gnt,
    output logic [WIDTH-1:0]      gnt_idx,
    output logic                  gnt_valid,
    output logic                  busy
);
    localparam int N = 1 << WIDTH;
    localparam bit HOLD_EN = (MAX_HOLD != 0);
    localparam logic [CW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        HANDOFF = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0] idx_q, idx_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             win_vld;
    logic [WIDTH-1:0] win_idx;
    logic [N-1:0]     owner_onehot;
    logic             owner_req;
    logic             others_req;
    logic             tenure_done;

    // Rotating priority search. Walk offsets from farthest to nearest so the
    // requester closest to ptr (in wrap order) is the last one to overwrite.
    always_comb begin
        logic [WIDTH-1:0] cand;
        win_vld = 1'b0;
        win_idx = ptr_q;
        cand    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = ptr_q + WIDTH'(i);
            if (req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    assign owner_onehot = N'(1) << idx_q;
    assign owner_req    = req[idx_q];
    assign others_req   = |(req & ~owner_onehot);
    assign tenure_done  = HOLD_EN && (cnt_q == HOLD_LAST);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, HANDOFF: begin
                if (win_vld) begin
                    state_d = GRANT;
                    idx_d   = win_idx;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (!owner_req || (tenure_done && others_req)) begin
                    // Owner moves to lowest priority for the next arbitration.
                    state_d = HANDOFF;
                    ptr_d   = idx_q + WIDTH'(1);
                end else if (tenure_done) begin
                    // Nobody else waiting: restart the tenure window, keep the bus.
                    cnt_d = '0;
                end else if (HOLD_EN) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // All outputs derive from registers only.
    assign gnt_valid = (state_q == GRANT);
    assign busy      = (state_q != IDLE);
    assign gnt_idx   = idx_q;

    decoder #(.WIDTH(WIDTH)) u_dec (
        .a_i  (idx_q),
        .en_i (gnt_valid),
        .y_o  (gnt)
    );
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter (WIDTH=3, MAX_HOLD=4): expected outputs are
// queued with each driven cycle and checked one edge later.
// No backpressure; the bench drives req directly.
module tb_bus_arbiter;
    localparam int WIDTH    = 3;
    localparam int N        = 8;
    localparam int MAX_HOLD = 4;
    localparam int CW       = 5;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic [2:0]   gnt_idx;
    logic         gnt_valid;
    logic         busy;

    typedef struct packed {
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       vld;
        logic       busy;
    } obs_t;

    obs_t exp_q[$];
    int   n_asserts = 0;
    int   n_fail    = 0;
    int   step_no   = 0;

    bus_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input obs_t e);
        chk({tag, ".gnt"},  32'(gnt),       32'(e.gnt));
        chk({tag, ".idx"},  32'(gnt_idx),   32'(e.idx));
        chk({tag, ".vld"},  32'(gnt_valid), 32'(e.vld));
        chk({tag, ".busy"}, 32'(busy),      32'(e.busy));
    endtask

    // Drive req for one cycle, queue what the outputs must be after the edge,
    // then pop and compare once the edge has passed.
    task automatic cyc(input logic [7:0] r, input logic [7:0] eg, input logic [2:0] ei,
                       input logic ev, input logic eb);
        obs_t e;
        req = r;
        e.gnt = eg; e.idx = ei; e.vld = ev; e.busy = eb;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        step_no++;
        e = exp_q.pop_front();
        check_outputs($sformatf("step%0d", step_no), e);
    endtask

    // Pulse reset between edges (entered at edge+1), check outputs cleared
    // without a clock, release before the next edge.
    task automatic pulse_reset(input string tag);
        obs_t z;
        z = '0;
        #2 rst_n = 1'b0;
        #1 check_outputs(tag, z);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        obs_t z;
        z     = '0;
        rst_n = 1'b0;
        req   = '0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs("in_reset", z);
        rst_n = 1'b1;

        // Idle after reset release
        for (int i = 0; i < 5; i++) cyc(8'h00, 8'h00, 3'd0, 1'b0, 1'b0);

        // Single requester, grant then release
        cyc(8'h04, 8'h04, 3'd2, 1'b1, 1'b1);
        cyc(8'h00, 8'h00, 3'd2, 1'b0, 1'b1);
        cyc(8'h00, 8'h00, 3'd2, 1'b0, 1'b0);

        // Round-robin from a fresh pointer: 0..7 then 0, with one gap each
        pulse_reset("rst_before_rr");
        for (int i = 0; i < N; i++) begin
            logic [7:0] one;
            one = 8'(1 << i);
            cyc(8'hFF, one, 3'(i), 1'b1, 1'b1);
            cyc(8'hFF & ~one, 8'h00, 3'(i), 1'b0, 1'b1);
        end
        cyc(8'hFF, 8'h01, 3'd0, 1'b1, 1'b1);
        cyc(8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
        cyc(8'h00, 8'h00, 3'd0, 1'b0, 1'b0);

        // Preemption: owner 1 holds 4 cycles, gap, owner 5 holds 4, gap, back to 1
        cyc(8'h02, 8'h02, 3'd1, 1'b1, 1'b1);
        for (int i = 0; i < MAX_HOLD - 1; i++) cyc(8'h22, 8'h02, 3'd1, 1'b1, 1'b1);
        cyc(8'h22, 8'h00, 3'd1, 1'b0, 1'b1);
        for (int i = 0; i < MAX_HOLD; i++) cyc(8'h22, 8'h20, 3'd5, 1'b1, 1'b1);
        cyc(8'h22, 8'h00, 3'd5, 1'b0, 1'b1);
        cyc(8'h22, 8'h02, 3'd1, 1'b1, 1'b1);
        cyc(8'h00, 8'h00, 3'd1, 1'b0, 1'b1);
        cyc(8'h00, 8'h00, 3'd1, 1'b0, 1'b0);

        // Sole owner keeps the bus well past MAX_HOLD with no gap
        for (int i = 0; i < 21; i++) cyc(8'h08, 8'h08, 3'd3, 1'b1, 1'b1);
        cyc(8'h00, 8'h00, 3'd3, 1'b0, 1'b1);
        cyc(8'h00, 8'h00, 3'd3, 1'b0, 1'b0);

        // Pointer is now 4: simultaneous requests 1,3,6 -> 6 wins, not the lowest
        cyc(8'h4A, 8'h40, 3'd6, 1'b1, 1'b1);
        cyc(8'h00, 8'h00, 3'd6, 1'b0, 1'b1);
        cyc(8'h00, 8'h00, 3'd6, 1'b0, 1'b0);

        // Async reset mid-grant of owner 6, req[6] stays high
        cyc(8'h40, 8'h40, 3'd6, 1'b1, 1'b1);
        req = 8'h40;
        pulse_reset("rst_mid_grant");
        cyc(8'h40, 8'h40, 3'd6, 1'b1, 1'b1);
        cyc(8'h00, 8'h00, 3'd6, 1'b0, 1'b1);
        cyc(8'h00, 8'h00, 3'd6, 1'b0, 1'b0);

        // Pointer was 7; after reset it must be 0, so 0 beats 7
        pulse_reset("rst_ptr");
        cyc(8'h81, 8'h01, 3'd0, 1'b1, 1'b1);
        // Requester 7 arrives as owner 0 leaves: eligible in that handoff
        cyc(8'h80, 8'h00, 3'd0, 1'b0, 1'b1);
        cyc(8'h80, 8'h80, 3'd7, 1'b1, 1'b1);
        cyc(8'h00, 8'h00, 3'd7, 1'b0, 1'b1);
        cyc(8'h00, 8'h00, 3'd7, 1'b0, 1'b0);

        // Sub-cycle pulse between edges is never seen
        req = 8'h10;
        #2 req = 8'h00;
        cyc(8'h00, 8'h00, 3'd7, 1'b0, 1'b0);
        cyc(8'h00, 8'h00, 3'd7, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    // Hard time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: observed still running expected finished");
        $fatal(1, "timeout");
    end
endmodule
